// File: rtl/riscv_regfile_pkg.sv
// Shared types and defaults for the pipelined RISC-V register file.
package riscv_regfile_pkg;

   localparam int RF_XLEN_DEF  = 32;
   localparam int RF_NREG_DEF  = 32;
   localparam int RF_AW_DEF    = 5;
   localparam int RF_MAX_DELAY = 4;
   localparam int RF_MAX_RD    = 4;

   typedef struct packed {
      logic                 valid;
      logic [RF_AW_DEF-1:0] addr;
   } wb_entry_t;

   function automatic bit is_pow2(int n);
      return (n > 1) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/riscv_regfile_pipe_if.sv
// Decode/write-back side bus of the register file: issue, write data, stall/flush, read ports.
interface riscv_regfile_pipe_if
   import riscv_regfile_pkg::*;
#(
   parameter int XLEN = RF_XLEN_DEF,
   parameter int AW   = RF_AW_DEF,
   parameter int NRD  = 2
);
   logic                      issue_i;
   logic                      we_i;
   logic [AW-1:0]             AddrD_i;
   logic [XLEN-1:0]           DataD_i;
   logic                      stall_i;
   logic                      flush_i;
   logic [NRD-1:0][AW-1:0]    AddrR_i;
   logic [NRD-1:0][XLEN-1:0]  DataR_o;
   logic [NRD-1:0]            Busy_o;

   modport master (
      output issue_i, we_i, AddrD_i, DataD_i, stall_i, flush_i, AddrR_i,
      input  DataR_o, Busy_o
   );

   modport slave (
      input  issue_i, we_i, AddrD_i, DataD_i, stall_i, flush_i, AddrR_i,
      output DataR_o, Busy_o
   );
endinterface

// File: rtl/riscv_wb_tracker.sv
// Destination-address tracking pipeline: shifts {valid, addr} towards the write-back tail
// and flags read addresses that still have an uncommitted writer in flight.
module riscv_wb_tracker
   import riscv_regfile_pkg::*;
#(
   parameter int AW       = RF_AW_DEF,
   parameter int NRD      = 2,
   parameter int WB_DELAY = 3,
   parameter int ZERO_REG = 1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   issue_i,
   input  logic                   we_i,
   input  logic [AW-1:0]          addr_i,
   input  logic                   stall_i,
   input  logic                   flush_i,
   input  logic [NRD-1:0][AW-1:0] rd_addr_i,
   output logic                   tail_valid_o,
   output logic [AW-1:0]          tail_addr_o,
   output logic [NRD-1:0]         busy_o
);

   typedef struct packed {
      logic          valid;
      logic [AW-1:0] addr;
   } entry_t;

   entry_t         stage_q [WB_DELAY];
   entry_t         stage_d [WB_DELAY];
   logic           zero_dst_s;
   logic           push_s;
   logic [NRD-1:0] busy_s;

   assign zero_dst_s = (ZERO_REG != 0) && (addr_i == {AW{1'b0}});
   assign push_s     = issue_i & we_i & ~stall_i & ~flush_i & ~zero_dst_s;

   // Next stage contents: a stall freezes the tail even when flush clears the younger stages.
   always_comb begin
      for (int n = 0; n < WB_DELAY; n++) begin
         stage_d[n] = stage_q[n];
      end
      if (stall_i) begin
         if (flush_i) begin
            for (int n = 0; n < WB_DELAY - 1; n++) begin
               stage_d[n].valid = 1'b0;
            end
         end else begin
            for (int n = 0; n < WB_DELAY; n++) begin
               stage_d[n] = stage_q[n];
            end
         end
      end else if (flush_i) begin
         for (int n = 0; n < WB_DELAY; n++) begin
            stage_d[n].valid = 1'b0;
         end
      end else begin
         stage_d[0].valid = push_s;
         stage_d[0].addr  = addr_i;
         for (int n = 1; n < WB_DELAY; n++) begin
            stage_d[n] = stage_q[n-1];
         end
      end
   end

   // Stage registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int n = 0; n < WB_DELAY; n++) begin
            stage_q[n].valid <= 1'b0;
            stage_q[n].addr  <= {AW{1'b0}};
         end
      end else begin
         for (int n = 0; n < WB_DELAY; n++) begin
            stage_q[n] <= stage_d[n];
         end
      end
   end

   // Busy compare against non-tail stages only; the tail is covered by the bypass.
   always_comb begin
      for (int p = 0; p < NRD; p++) begin
         busy_s[p] = 1'b0;
         for (int n = 0; n < WB_DELAY - 1; n++) begin
            busy_s[p] = busy_s[p] | (stage_q[n].valid & (stage_q[n].addr == rd_addr_i[p]));
         end
         busy_s[p] = busy_s[p] & ~((ZERO_REG != 0) && (rd_addr_i[p] == {AW{1'b0}}));
      end
   end

   assign busy_o       = busy_s;
   assign tail_valid_o = stage_q[WB_DELAY-1].valid;
   assign tail_addr_o  = stage_q[WB_DELAY-1].addr;

endmodule

// File: rtl/riscv_regfile_pipe.sv
// RISC-V integer register file with a configurable write-back tracking pipeline,
// write-to-read bypass, hardwired x0 and per-port busy flags.
module riscv_regfile_pipe
   import riscv_regfile_pkg::*;
#(
   parameter int XLEN     = RF_XLEN_DEF,
   parameter int NREG     = RF_NREG_DEF,
   parameter int NRD      = 2,
   parameter int WB_DELAY = 3,
   parameter int ZERO_REG = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   riscv_regfile_pipe_if.slave  rf
);

   localparam int AW = $clog2(NREG);

   if ((WB_DELAY < 1) || (WB_DELAY > RF_MAX_DELAY)) begin : g_bad_delay
      $error("riscv_regfile_pipe: WB_DELAY must be within 1..%0d", RF_MAX_DELAY);
   end
   if ((NRD < 1) || (NRD > RF_MAX_RD)) begin : g_bad_nrd
      $error("riscv_regfile_pipe: NRD must be within 1..%0d", RF_MAX_RD);
   end
   if (!is_pow2(NREG)) begin : g_bad_nreg
      $error("riscv_regfile_pipe: NREG must be a power of two");
   end

   logic                     tail_valid_s;
   logic [AW-1:0]            tail_addr_s;
   logic                     wr_en_s;
   logic [NRD-1:0]           busy_s;
   logic [NRD-1:0][XLEN-1:0] data_s;
   logic [XLEN-1:0]          regs_q [NREG];

   riscv_wb_tracker #(
      .AW       (AW),
      .NRD      (NRD),
      .WB_DELAY (WB_DELAY),
      .ZERO_REG (ZERO_REG)
   ) u_tracker (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .issue_i      (rf.issue_i),
      .we_i         (rf.we_i),
      .addr_i       (rf.AddrD_i),
      .stall_i      (rf.stall_i),
      .flush_i      (rf.flush_i),
      .rd_addr_i    (rf.AddrR_i),
      .tail_valid_o (tail_valid_s),
      .tail_addr_o  (tail_addr_s),
      .busy_o       (busy_s)
   );

   // A zero-destination never reaches the tail valid, so x0 stays at its reset value.
   assign wr_en_s = tail_valid_s & ~rf.stall_i;

   // Register storage.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= {XLEN{1'b0}};
         end
      end else if (wr_en_s) begin
         regs_q[tail_addr_s] <= rf.DataD_i;
      end
   end

   // Read ports: x0 gating, then tail bypass, then storage.
   always_comb begin
      for (int p = 0; p < NRD; p++) begin
         data_s[p] = {XLEN{1'b0}};
         if ((ZERO_REG != 0) && (rf.AddrR_i[p] == {AW{1'b0}})) begin
            data_s[p] = {XLEN{1'b0}};
         end else if (wr_en_s && (tail_addr_s == rf.AddrR_i[p])) begin
            data_s[p] = rf.DataD_i;
         end else begin
            data_s[p] = regs_q[rf.AddrR_i[p]];
         end
      end
   end

   assign rf.DataR_o = data_s;
   assign rf.Busy_o  = busy_s;

endmodule

// File: doc/riscv_regfile_pipe.md
# riscv_regfile_pipe

Parametrised RISC-V integer register file with multiple combinational read ports and a built-in destination-address tracking pipeline. It replaces the fixed 3-cycle address delay with a configurable write-back depth, adds stall and flush control, write-to-read bypass, a hardwired x0, and per-port busy flags for hazard detection. It sits between decode, which issues destinations, and write-back, which supplies result data `WB_DELAY` cycles later.

## Interface
- `XLEN`, 32: register width in bits.
- `NREG`, 32: number of registers, power of two; `AW = $clog2(NREG)`.
- `NRD`, 2: number of read ports, 1..4.
- `WB_DELAY`, 3: edges from issue to write, 1..4.
- `ZERO_REG`, 1: 1 makes register 0 read as zero and never written.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `issue_i` in 1: decode issues an instruction this cycle.
- `we_i` in 1: the issued instruction writes a destination.
- `AddrD_i` in AW: destination of the issued instruction.
- `DataD_i` in XLEN: write-back data for the entry currently at the tail stage.
- `stall_i` in 1: freeze the tracking pipeline.
- `flush_i` in 1: kill in-flight, non-tail entries.
- `AddrR_i` in NRD×AW: read addresses, one per port.
- `DataR_o` out NRD×XLEN: read data, one per port.
- `Busy_o` out NRD: the port's address has a pending writer whose data is not yet available.

## Operation
- Tracking pipeline: stages 1..`WB_DELAY`, each holding {valid, addr}. Stage `WB_DELAY` is the tail.
- Push: on an edge with `issue_i & we_i & !stall_i & !flush_i`, stage 1 gets {1, `AddrD_i`}. If `ZERO_REG` and `AddrD_i==0`, stage 1 gets valid=0 instead. Otherwise stage 1 gets valid=0.
- Advance: each non-stalled edge, stage n+1 takes stage n.
- Write: on a non-stalled edge where the tail is valid, `Registers[tail.addr] <= DataD_i`.
- Stall: all stages hold. No write occurs. `issue_i` is ignored, so upstream must hold it.
- Flush: stages 1..`WB_DELAY`-1 are cleared on the edge. The tail still writes, since it is committed. A same-cycle issue is dropped.
- Flush and stall together: non-tail stages clear, the tail holds, and no write occurs.
- Read, per port p:
  - If `ZERO_REG` and `AddrR_i[p]==0`, `DataR_o[p]=0`.
  - Else, if the tail is valid, not stalled, and `tail.addr==AddrR_i[p]`, `DataR_o[p]=DataD_i` (bypass).
  - Otherwise `DataR_o[p]=Registers[AddrR_i[p]]`.
- Busy: `Busy_o[p]=1` iff some valid stage 1..`WB_DELAY`-1 matches `AddrR_i[p]` and the address is not zero-gated. The tail is excluded because it is bypassed.
- Ordering: with several valid entries to the same address, the youngest write lands last, so it wins naturally.

## Timing
- Issue sampled at edge E0 → write committed at edge E`WB_DELAY`, provided there is no stall. Each stalled edge adds one cycle.
- Reads and `Busy_o` are combinational from `AddrR_i`, pipeline state and `DataD_i`; latency is 0 cycles.
- Reset, asynchronous, while `rst_ni=0`:
  - all registers = 0;
  - all stage valids = 0;
  - therefore `DataR_o=0` and `Busy_o=0`.
- Reset release is synchronised externally. The first issue can be sampled on the first edge with `rst_ni=1`.
- Reset asserted mid-operation drops all in-flight writes, and no partial write occurs.
- `WB_DELAY=1`: the tail is stage 1. Busy is never asserted; only bypass applies.

## Structure
- Package `riscv_regfile_pkg`:
  - `wb_entry_t` typedef: {logic valid; logic [AW-1:0] addr}, parametrised via a localparam default of 5;
  - constants `RF_XLEN_DEF`, `RF_NREG_DEF`, `RF_MAX_DELAY=4`.
- Sub-module `riscv_wb_tracker`: the stage shift register with push, stall and flush, plus the NRD busy comparators. It exports the tail entry.
- The top holds the storage array, write logic and read/bypass muxes.
- Elaboration-time checks reject: `WB_DELAY` outside 1..4, `NRD` outside 1..4, and non-power-of-two `NREG`.

## Test plan
- **Reset and write latency:** reset, then issue x5 with `DataD_i=32'hDEADBEEF` held. With `WB_DELAY=3`, port 0 reading x5 returns 0 until the tail cycle, bypasses `DEADBEEF` in the tail cycle, and reads `DEADBEEF` from storage afterwards.
- **Zero register:** issue x0 with `DataD_i=32'hFFFFFFFF`. x0 reads 0 on all ports at all times, and `Busy_o` never asserts for address 0.
- **Busy and bypass:** issue x7 and read x7 on port 1. `Busy_o[1]=1` for 2 cycles, then 0 with `DataR_o[1]=DataD_i` in the tail cycle.
- **Stall:** issue x3, then stall for 2 cycles mid-flight. The write lands 2 edges later (E5), and DataD applied during the stall is not written.
- **Flush:** issue x9 then x10 on consecutive cycles, and assert flush while x9 is at the tail. x9 is written, x10 is never written, and `Busy_o` for x10 clears on the flush edge.
- **Async reset mid-flight:** pulse `rst_ni` low between edges while entries are in flight. Outputs go to 0 immediately, and no write occurs at later edges.
